// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage RV32 pipeline.
//   Hazard inputs : dmem_req_mem/dmem_ready (data-memory wait), mdu_op_ex/mdu_done (MUL/DIV),
//                   branch_taken_ex (EX redirect), mem_read_idex/rd_idex/rs1_ifid/rs2_ifid (load-use)
//   Stage controls: pc_write, ifid_write/flush, idex_write/flush, exmem_write/flush, memwb_flush
//   MDU handshake : mdu_go start pulse, mdu_timeout sticky watchdog error
//   Perf counter  : stall_cycles, saturating count of cycles with pc_write=0
module pipeline_stall_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_idex,
  input  logic [4:0]       rd_idex,
  input  logic [4:0]       rs1_ifid,
  input  logic [4:0]       rs2_ifid,
  input  logic             branch_taken_ex,
  input  logic             mdu_op_ex,
  input  logic             mdu_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mdu_go,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  typedef enum logic {RUN, MDU_BUSY} state_t;
  state_t state_q, state_d;
  logic done_latch_q, done_latch_d;
  logic mdu_timeout_q, mdu_timeout_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic dstall, lu, busy, wd_hit, done, mstall, adv;
  always_comb begin
    dstall = dmem_req_mem & ~dmem_ready;
    lu = mem_read_idex & (rd_idex != 5'd0) & ((rd_idex == rs1_ifid) | (rd_idex == rs2_ifid));
    busy = state_q == MDU_BUSY;
    // >= rather than == so a watchdog expiry masked by a data-memory wait still releases afterwards
    wd_hit = wd_q >= WD_W'(MDU_TIMEOUT - 1);
    done = mdu_done | done_latch_q;
    mstall = busy ? ~(done | wd_hit) : mdu_op_ex;
    // EX and everything upstream may move this cycle
    adv = rst_n & ~dstall & ~mstall;
    pc_write = adv & (branch_taken_ex | ~lu);
    ifid_write = adv & (branch_taken_ex | ~lu);
    ifid_flush = ~rst_n | (adv & branch_taken_ex);
    idex_write = adv;
    idex_flush = ~rst_n | (adv & (branch_taken_ex | lu));
    exmem_write = rst_n & ~dstall;
    exmem_flush = ~rst_n | (~dstall & mstall);
    memwb_flush = ~rst_n | dstall;
    mdu_go = rst_n & ~busy & mdu_op_ex & ~dstall;
    state_d = busy ? ((mstall | dstall) ? MDU_BUSY : RUN) : (mdu_go ? MDU_BUSY : RUN);
    // a done pulse that lands while memory freezes the pipe is held until the release can happen
    done_latch_d = busy & dstall & done;
    wd_d = ~busy ? '0 : (wd_q == WD_W'(MDU_TIMEOUT)) ? wd_q : wd_q + 1'b1;
    mdu_timeout_d = mdu_timeout_q | (busy & wd_hit & ~done);
    stall_cycles_d = (~pc_write & ~&stall_cycles_q) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      done_latch_q <= 1'b0;
      wd_q <= '0;
      mdu_timeout_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      done_latch_q <= done_latch_d;
      wd_q <= wd_d;
      mdu_timeout_q <= mdu_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign mdu_timeout = mdu_timeout_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and random checks of pipeline_stall_ctrl against a cycle model.
module tb_pipeline_stall_ctrl;
  localparam int TO = 8;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  // output vector order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f, mdu_go
  localparam logic [8:0] V_RST = 9'b001010110;
  localparam logic [8:0] V_DEF = 9'b110101000;
  localparam logic [8:0] V_DS  = 9'b000000010;
  localparam logic [8:0] V_MS  = 9'b000001100;
  localparam logic [8:0] V_BR  = 9'b111111000;
  localparam logic [8:0] V_LU  = 9'b000111000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read_idex = 1'b0;
  logic [4:0] rd_idex = '0, rs1_ifid = '0, rs2_ifid = '0;
  logic branch_taken_ex = 1'b0, mdu_op_ex = 1'b0, mdu_done = 1'b0;
  logic dmem_req_mem = 1'b0, dmem_ready = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_write, exmem_flush, memwb_flush, mdu_go, mdu_timeout;
  logic [CW-1:0] stall_cycles;
  logic [8:0] obs;
  int checks = 0;
  int failures = 0;
  bit m_busy, m_latch, m_to;
  int m_age, m_cnt;
  pipeline_stall_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_idex(mem_read_idex), .rd_idex(rd_idex),
    .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid), .branch_taken_ex(branch_taken_ex),
    .mdu_op_ex(mdu_op_ex), .mdu_done(mdu_done), .dmem_req_mem(dmem_req_mem),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .mdu_go(mdu_go), .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
  );
  assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                exmem_write, exmem_flush, memwb_flush, mdu_go};
  always #5 clk = ~clk;
  function automatic logic [8:0] exp_out();
    bit ds, luh, ms;
    ds = dmem_req_mem && !dmem_ready;
    luh = mem_read_idex && rd_idex != 0 && (rd_idex == rs1_ifid || rd_idex == rs2_ifid);
    ms = m_busy ? !(mdu_done || m_latch || m_age >= TO - 1) : mdu_op_ex;
    if (!rst_n) return V_RST;
    if (ds) return V_DS;
    if (ms) return V_MS | {8'b0, !m_busy};
    if (branch_taken_ex) return V_BR;
    if (luh) return V_LU;
    return V_DEF;
  endfunction
  task automatic model_step();
    logic [8:0] e;
    bit ds, done, hit;
    e = exp_out();
    ds = dmem_req_mem && !dmem_ready;
    done = mdu_done || m_latch;
    hit = m_age >= TO - 1;
    if (!rst_n) begin
      m_busy = 0; m_latch = 0; m_to = 0; m_age = 0; m_cnt = 0;
      return;
    end
    if (!e[8] && m_cnt < CMAX) m_cnt++;
    if (m_busy) begin
      if (hit && !done) m_to = 1;
      if ((done || hit) && !ds) begin
        m_busy = 0; m_latch = 0; m_age = 0;
      end else begin
        m_age++;
        if (ds && mdu_done) m_latch = 1;
      end
    end else if (mdu_op_ex && !ds) begin
      m_busy = 1; m_age = 0;
    end
  endtask
  task automatic clear_inputs();
    rst_n = 1; mem_read_idex = 0; rd_idex = 0; rs1_ifid = 0; rs2_ifid = 0;
    branch_taken_ex = 0; mdu_op_ex = 0; mdu_done = 0; dmem_req_mem = 0; dmem_ready = 0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst_n = (i == 3); mdu_op_ex = (i != 3); dmem_req_mem = (i == 1); mem_read_idex = 1;
      #2;
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL reset_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (i < 3 && obs !== V_RST) begin failures++; $display("FAIL reset_vec cyc=%0d got=%b exp=%b", i, obs, V_RST); end
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      checks++; if (mdu_timeout !== m_to) begin failures++; $display("FAIL reset_to cyc=%0d got=%b exp=%b", i, mdu_timeout, m_to); end
      model_step(); @(negedge clk);
    end
    clear_inputs();
  endtask
  task automatic test_load_use();
    int s0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      mem_read_idex = (i < 2); rd_idex = (i == 0) ? 5'd5 : 5'd0; rs1_ifid = (i < 2) ? 5'd5 : 5'd0; rs2_ifid = 5'd0;
      if (i == 0) s0 = int'(stall_cycles);
      #2;
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL lu_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL lu_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      if (i == 0) begin checks++; if (obs !== V_LU) begin failures++; $display("FAIL lu_vec got=%b exp=%b", obs, V_LU); end end
      if (i == 1) begin
        checks++; if (obs !== V_DEF) begin failures++; $display("FAIL lu_rd0 got=%b exp=%b", obs, V_DEF); end
        checks++; if (int'(stall_cycles) !== s0 + 1) begin failures++; $display("FAIL lu_inc got=%0d exp=%0d", stall_cycles, s0 + 1); end
      end
      model_step(); @(negedge clk);
    end
  endtask
  task automatic test_branch_vs_lu();
    int s0;
    clear_inputs();
    mem_read_idex = 1; rd_idex = 5'd7; rs2_ifid = 5'd7; branch_taken_ex = 1;
    s0 = int'(stall_cycles);
    #2;
    checks++; if (obs !== V_BR) begin failures++; $display("FAIL br_vec got=%b exp=%b", obs, V_BR); end
    checks++; if (obs !== exp_out()) begin failures++; $display("FAIL br_ctl got=%b exp=%b", obs, exp_out()); end
    model_step(); @(negedge clk);
    clear_inputs(); #2;
    checks++; if (int'(stall_cycles) !== s0) begin failures++; $display("FAIL br_cnt got=%0d exp=%0d", stall_cycles, s0); end
  endtask
  task automatic test_mdu();
    int s0, gos;
    clear_inputs();
    gos = 0; s0 = int'(stall_cycles);
    for (int i = 0; i < 6; i++) begin
      mdu_op_ex = (i < 5); mdu_done = (i == 4);
      #2;
      gos += int'(mdu_go);
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL mdu_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL mdu_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      if (i == 4) begin checks++; if (obs !== V_DEF) begin failures++; $display("FAIL mdu_release got=%b exp=%b", obs, V_DEF); end end
      model_step(); @(negedge clk);
    end
    #2;
    checks++; if (gos !== 1) begin failures++; $display("FAIL mdu_go_count got=%0d exp=1", gos); end
    checks++; if (int'(stall_cycles) !== s0 + 4) begin failures++; $display("FAIL mdu_stalls got=%0d exp=%0d", stall_cycles, s0 + 4); end
  endtask
  task automatic test_done_during_dmem();
    int gos;
    clear_inputs();
    gos = 0;
    for (int i = 0; i < 7; i++) begin
      mdu_op_ex = (i < 6); dmem_req_mem = (i >= 2 && i <= 4); mdu_done = (i == 3);
      #2;
      gos += int'(mdu_go);
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL dd_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL dd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      if (i >= 2 && i <= 4) begin checks++; if (obs !== V_DS) begin failures++; $display("FAIL dd_freeze cyc=%0d got=%b exp=%b", i, obs, V_DS); end end
      if (i == 5) begin checks++; if (obs !== V_DEF) begin failures++; $display("FAIL dd_release got=%b exp=%b", obs, V_DEF); end end
      model_step(); @(negedge clk);
    end
    checks++; if (gos !== 1) begin failures++; $display("FAIL dd_go_count got=%0d exp=1", gos); end
  endtask
  task automatic test_watchdog();
    clear_inputs();
    for (int i = 0; i < 13; i++) begin
      mdu_op_ex = (i < 9);
      #2;
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL wd_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (mdu_timeout !== m_to) begin failures++; $display("FAIL wd_model cyc=%0d got=%b exp=%b", i, mdu_timeout, m_to); end
      checks++; if (mdu_timeout !== (i >= 9)) begin failures++; $display("FAIL wd_sticky cyc=%0d got=%b exp=%b", i, mdu_timeout, i >= 9); end
      if (i == 7) begin checks++; if (obs !== V_MS) begin failures++; $display("FAIL wd_stall got=%b exp=%b", obs, V_MS); end end
      if (i == 8) begin checks++; if (obs !== V_DEF) begin failures++; $display("FAIL wd_release got=%b exp=%b", obs, V_DEF); end end
      model_step(); @(negedge clk);
    end
  endtask
  task automatic test_reset_mid_stall();
    int gos;
    clear_inputs();
    gos = 0;
    for (int i = 0; i < 9; i++) begin
      rst_n = !(i == 2 || i == 3); mdu_op_ex = (i <= 3) || i == 6 || i == 7;
      dmem_req_mem = (i >= 1 && i <= 3); mdu_done = (i == 1) || (i == 7);
      #2;
      if (i >= 2 && i <= 5) gos += int'(mdu_go);
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL rms_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL rms_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      if (i == 2) begin checks++; if (obs !== V_RST) begin failures++; $display("FAIL rms_vec got=%b exp=%b", obs, V_RST); end end
      if (i == 4) begin
        checks++; if (stall_cycles !== '0) begin failures++; $display("FAIL rms_cnt0 got=%0d exp=0", stall_cycles); end
        checks++; if (mdu_timeout !== 1'b0) begin failures++; $display("FAIL rms_to0 got=%b exp=0", mdu_timeout); end
        checks++; if (obs !== V_DEF) begin failures++; $display("FAIL rms_idle got=%b exp=%b", obs, V_DEF); end
      end
      if (i == 6) begin checks++; if (mdu_go !== 1'b1) begin failures++; $display("FAIL rms_newgo got=%b exp=1", mdu_go); end end
      model_step(); @(negedge clk);
    end
    checks++; if (gos !== 0) begin failures++; $display("FAIL rms_nogo got=%0d exp=0", gos); end
  endtask
  task automatic test_saturation();
    clear_inputs();
    dmem_req_mem = 1;
    for (int i = 0; i < 270; i++) begin
      #2;
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      model_step(); @(negedge clk);
    end
    clear_inputs(); #2;
    checks++; if (stall_cycles !== CW'(CMAX)) begin failures++; $display("FAIL sat_max got=%0d exp=%0d", stall_cycles, CMAX); end
    model_step(); @(negedge clk); #2;
    checks++; if (stall_cycles !== CW'(CMAX)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", stall_cycles, CMAX); end
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_n = $urandom_range(0, 59) != 0;
      mem_read_idex = $urandom_range(0, 1) == 1;
      rd_idex = 5'($urandom_range(0, 3)); rs1_ifid = 5'($urandom_range(0, 3)); rs2_ifid = 5'($urandom_range(0, 3));
      branch_taken_ex = $urandom_range(0, 7) == 0;
      mdu_op_ex = $urandom_range(0, 3) == 0;
      mdu_done = $urandom_range(0, 9) == 0;
      dmem_req_mem = $urandom_range(0, 2) == 0;
      dmem_ready = $urandom_range(0, 1) == 1;
      #2;
      checks++; if (obs !== exp_out()) begin failures++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, obs, exp_out()); end
      checks++; if (stall_cycles !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cnt); end
      checks++; if (mdu_timeout !== m_to) begin failures++; $display("FAIL rnd_to cyc=%0d got=%b exp=%b", i, mdu_timeout, m_to); end
      model_step(); @(negedge clk);
    end
    clear_inputs();
  endtask
  initial begin
    m_busy = 0; m_latch = 0; m_to = 0; m_age = 0; m_cnt = 0;
    rst_n = 0;
    model_step();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_vs_lu();
    test_mdu();
    test_done_during_dmem();
    test_watchdog();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. Arbitrates four hazard sources and drives per-stage write-enables and flushes from one point:
- data-memory wait
- multi-cycle MUL/DIV unit
- taken branch/jump redirect in EX
- load-use
It owns the MUL/DIV start/wait handshake with a watchdog, and keeps a stall-cycle performance counter.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced release (>=2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
mem_read_idex  input  1  instruction in ID/EX is a load
rd_idex  input  5  destination register of ID/EX
rs1_ifid  input  5  source 1 of IF/ID instruction
rs2_ifid  input  5  source 2 of IF/ID instruction
branch_taken_ex  input  1  EX resolved a taken branch/jump (PC mux selects target)
mdu_op_ex  input  1  EX holds a MUL/DIV instruction (level)
mdu_done  input  1  MDU result valid, single-cycle pulse
dmem_req_mem  input  1  MEM stage issuing a data-memory access
dmem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC register load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads NOP
idex_write  output  1  ID/EX load enable
idex_flush  output  1  ID/EX loads bubble (control zeroed)
exmem_write  output  1  EX/MEM load enable
exmem_flush  output  1  EX/MEM loads bubble
memwb_flush  output  1  MEM/WB loads bubble
mdu_go  output  1  one-cycle start pulse to MDU
mdu_timeout  output  1  sticky error: watchdog fired
stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- State register: RUN, MDU_BUSY. Also registered: done_latch (1b), watchdog counter wd (clog2(MDU_TIMEOUT+1) bits), mdu_timeout, stall_cycles. Stage controls are combinational from state plus inputs (zero-latency stall).
- Reset (rst_n=0 at clk edge):
  - state=RUN, done_latch=0, wd=0, mdu_timeout=0, stall_cycles=0.
  - Combinational outputs while rst_n=0: all *_write=0, all *_flush=1, mdu_go=0.
- Hazard terms:
  - dstall = dmem_req_mem & ~dmem_ready.
  - lu = mem_read_idex & (rd_idex!=0) & (rd_idex==rs1_ifid | rd_idex==rs2_ifid).
  - mstall = (state==RUN & mdu_op_ex) | (state==MDU_BUSY & ~(mdu_done|done_latch)).
- Default outputs: all writes 1, flushes 0, mdu_go 0.
- Priority 1, dstall: pc/ifid/idex/exmem_write=0, memwb_flush=1.
- Priority 2, mstall (no dstall): pc/ifid/idex/exmem_write... more precisely pc/ifid/idex_write=0, exmem_flush=1.
- Priority 3, branch_taken_ex: pc_write=1, ifid_flush=1, idex_flush=1.
- Priority 4, lu: pc_write=0, ifid_write=0, idex_flush=1.
- Otherwise: defaults.
- Lower-priority hazards suppressed in a cycle are not remembered. They re-present naturally because the affected stages are frozen.
- FSM transitions:
  - RUN -> MDU_BUSY when mdu_op_ex & ~dstall. mdu_go=1 that cycle only; wd<=0.
  - If dstall & mdu_op_ex in RUN: stay in RUN, no mdu_go, retry next cycle.
  - MDU_BUSY: wd increments each cycle (dstall included).
  - Done release: if (mdu_done|done_latch) & ~dstall -> release cycle (all EX-and-upstream stages advance, defaults apply), state<=RUN, done_latch<=0.
  - Done during freeze: mdu_done arriving while dstall -> done_latch<=1, stay in MDU_BUSY.
  - Watchdog: wd==MDU_TIMEOUT-1 with no done -> mdu_timeout<=1 (sticky until reset), forced release as for done (subject to dstall).
  - mdu_done outside MDU_BUSY is ignored.
  - Back-to-back MDU ops: the release cycle returns to RUN; the next op is seen in RUN next cycle and gets a fresh mdu_go.
- Counter: stall_cycles increments when rst_n=1 and pc_write=0; saturates at all-ones, no wrap.
- Branch and mstall together cannot occur in valid code (one EX instruction). If both assert, mstall wins.

Test Plan:
- Load-use: mem_read_idex=1, rd_idex=5, rs1_ifid=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cycles 0->1. Repeat with rd_idex=0 -> no stall.
- Branch vs load-use: branch_taken_ex=1 and lu same cycle -> pc_write=1, ifid_flush=1, idex_flush=1, stall_cycles unchanged.
- MDU: mdu_op_ex=1 held, mdu_done pulses 4 cycles after mdu_go -> mdu_go exactly 1 cycle; 4 cycles with pc_write=0 and exmem_flush=1; release cycle all writes=1; stall_cycles +=4; state back to RUN.
- Done during dmem wait: in MDU_BUSY, dstall for 3 cycles with mdu_done pulsed in cycle 2 -> all frozen, memwb_flush=1 during dstall; release on the first cycle dstall=0; no second mdu_go.
- Watchdog, MDU_TIMEOUT=8: mdu_done never arrives -> forced release after 8 MDU_BUSY cycles, mdu_timeout=1 and stays 1 until rst_n=0.
- Reset mid-stall: rst_n=0 during MDU_BUSY with done_latch=1 -> next cycle state=RUN, counters 0; while low all flushes=1 and writes=0; no mdu_go after reset until a new mdu_op_ex.
